event_encoder: RTL
==================

# event_encoder

Inverse of the 3-to-8 line decoder: it captures rising edges on 8 independent event lines and emits them one at a time as 3-bit binary codes over a valid/ready handshake. Simultaneous or closely spaced edges are held in a pending register and drained lowest-index-first. It sits between raw one-hot/multi-hot status lines (FSM outputs, buttons, decoder outputs) and any consumer that processes one encoded event per transfer.

## Interface
- No parameters; the width is fixed at 8 lines / 3-bit code.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- input_lines  in  8  event lines; a 0→1 transition on bit i is an event for code i
- code  out  3  encoded index of the presented event; stable while code_valid=1 and code_ready=0
- code_valid  out  1  code holds an event
- code_ready  in  1  consumer accepts code; a transfer occurs on a clock edge where code_valid=1 and code_ready=1
- pending_count  out  4  popcount of the pending register, 0..8; includes the presented event
- overflow  out  1  sticky; an event was lost because its line was already pending
- ovf_clr  in  1  clears overflow

## Operation
- Registers:
  - prev[7:0]: input_lines delayed one cycle.
  - pending[7:0]
  - code[2:0]
  - code_valid
  - overflow
- event = input_lines & ~prev, evaluated combinationally each cycle.
- Accept mask acc = onehot(code) when code_valid & code_ready, else 0.
- Pending update per edge: pending_next = (pending & ~acc) | event.
- State machine, encoded by code_valid:
  - IDLE (code_valid=0): if pending≠0, load code = lowest set index of pending and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (code_valid=1), no transfer: hold code and stay in PRESENT.
  - PRESENT, transfer: if (pending & ~acc) | event ≠ 0, load code = lowest set index of that value and stay in PRESENT. Otherwise go to IDLE.
- The presented event's bit stays set in pending until it is accepted.
- Overflow:
  - An event on bit i is lost when pending[i]=1 and acc[i]=0.
  - A lost event sets overflow on that edge.
  - ovf_clr=1 clears overflow on the edge. If a set and a clear occur on the same edge, the set wins.
- An event on the code being accepted in the same cycle is not lost: that bit stays pending and is presented again.
- pending_count = popcount(pending), computed combinationally from the registered pending.
- Arithmetic: pending_count is 4 bits and reaches at most 8, so it never wraps. code is always in 0..7.

## Timing
- Reset values:
  - prev = 8'hFF, so lines already high when reset is released do not generate events.
  - pending = 0, code = 0, code_valid = 0, pending_count = 0, overflow = 0.
- Reset asserted mid-operation: on the next edge, all state returns to the reset values, code_valid drops, and all pending events are discarded.
- Latency: a line that is 0 at edge k-1 and 1 at edge k sets pending after edge k. code_valid rises after edge k+1 if the block was IDLE. End-to-end latency is 2 cycles.
- Throughput: one code per cycle while code_ready=1 and events remain (back-to-back transfers, no bubble).
- Events arriving while in PRESENT never change code until the next transfer; priority is re-evaluated only at load.
- A line held high produces exactly one event. It must return low for at least one cycle before it can produce another.
- code_ready is ignored while code_valid=0.

## Test plan
- Reset with input_lines=8'hFF, then release and hold the lines: code_valid stays 0, pending_count=0, overflow=0.
- From 0, drive input_lines=8'b1010_0100 for one cycle with code_ready=1:
  - code_valid rises 2 cycles later.
  - codes 2, 5, 7 appear on consecutive cycles.
  - pending_count reads 3, 2, 1, then 0.
  - code_valid drops after the third transfer.
- Backpressure: pulse line 3 with code_ready=0 for 5 cycles: code=3 and code_valid=1 are held stable, then one transfer occurs when ready rises.
- Overflow: with line 1 pending and unaccepted, pulse line 1 again: overflow=1 and pending_count is unchanged. Assert ovf_clr together with a new overflow: overflow remains 1. Assert ovf_clr alone: overflow returns to 0.
- Same-cycle re-event: line 4 is presented and accepted on the same edge that line 4 rises again: overflow stays 0 and code 4 is presented again on the next cycle.
- Reset mid-drain with three events pending: after the reset edge, code_valid=0 and pending_count=0, and no stale codes appear afterwards.

Source files
------------

// File: rtl/event_encoder.sv
// rtl/event_encoder.sv - rising-edge capture on 8 lines, drained lowest-index-first as 3-bit codes
module event_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_lines,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [3:0] pending_count,
  output logic       overflow,
  input  logic       ovf_clr
);

  // PRESENT means an event is on the code output; the state is exactly code_valid.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] prev;
  logic [7:0] pending;
  logic [7:0] pending_next;
  logic [7:0] events;
  logic [7:0] acc;
  logic [7:0] lost;
  logic [2:0] code_next;
  logic       overflow_next;

  // Index of the lowest set bit; callers only use it on a non-zero vector.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Number of set bits in the pending register, 0..8.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Edge detection, accept mask and the pending update; an event is lost only if
  // its bit is pending and not being retired on this same edge.
  always_comb begin
    events       = input_lines & ~prev;
    acc          = 8'h00;
    if (state == PRESENT && code_ready) begin
      acc = 8'h01 << code;
    end
    pending_next = (pending & ~acc) | events;
    lost         = events & pending & ~acc;
  end

  // Next-state and code selection; priority is re-evaluated only when a code is loaded.
  always_comb begin
    state_next = state;
    code_next  = code;
    case (state)
      IDLE: begin
        if (|pending) begin
          code_next  = lowest_idx(pending);
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (code_ready) begin
          if (|pending_next) begin
            code_next = lowest_idx(pending_next);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky overflow: a new loss takes precedence over a clear on the same edge.
  always_comb begin
    overflow_next = overflow;
    if (|lost) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  // State registers; prev resets high so lines already asserted at release are not events.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 8'hFF;
      pending  <= 8'h00;
      code     <= 3'd0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      prev     <= input_lines;
      pending  <= pending_next;
      code     <= code_next;
      overflow <= overflow_next;
    end
  end

  // Outputs derived from registered state.
  always_comb begin
    code_valid    = (state == PRESENT);
    pending_count = popcount8(pending);
  end

endmodule
